// File: rtl/psu_tach_monitor_pkg.sv
// rtl/psu_tach_monitor_pkg.sv - shared types, defaults and helpers for the PSU tach monitor
package psu_tach_monitor_pkg;

    localparam int DEF_WINDOW_STROBES = 64;
    localparam int DEF_QUAL_WINDOWS   = 3;
    localparam int DEF_FILTER_LEN     = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2
    } tach_state_t;

    typedef enum logic [1:0] {
        CLS_OK   = 2'd0,
        CLS_LOW  = 2'd1,
        CLS_HIGH = 2'd2
    } tach_class_t;

    // LOW wins over HIGH so an inverted limit pair can never raise both flags
    function automatic tach_class_t classify(input logic [7:0] count,
                                             input logic [7:0] low_limit,
                                             input logic [7:0] high_limit);
        if (count < low_limit)  return CLS_LOW;
        if (count > high_limit) return CLS_HIGH;
        return CLS_OK;
    endfunction

    function automatic logic [1:0] qual_inc(input logic [1:0] q);
        return (q == 2'b11) ? q : q + 2'd1;
    endfunction

endpackage

// File: rtl/psu_tach_monitor_if.sv
// rtl/psu_tach_monitor_if.sv - control, limit and result signals of one PSU tach monitor
interface psu_tach_monitor_if;
    logic       Strobe16ms;
    logic       TachEnable;
    logic       PSU1_Tach;
    logic [7:0] TachLowLimit;
    logic [7:0] TachHighLimit;
    logic       PSU1_Tach_Low;
    logic       PSU1_Tach_High;
    logic [7:0] TachCount;
    logic       TachValid;

    modport master (
        output Strobe16ms, TachEnable, PSU1_Tach, TachLowLimit, TachHighLimit,
        input  PSU1_Tach_Low, PSU1_Tach_High, TachCount, TachValid
    );

    modport slave (
        input  Strobe16ms, TachEnable, PSU1_Tach, TachLowLimit, TachHighLimit,
        output PSU1_Tach_Low, PSU1_Tach_High, TachCount, TachValid
    );
endinterface

// File: rtl/psu_tach_monitor_tach_filter.sv
// rtl/psu_tach_monitor_tach_filter.sv - tach synchronizer, glitch filter and rising-edge detector
module tach_filter
    import psu_tach_monitor_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic tach_raw,
    output logic tach_rise
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic [CW-1:0] run_q, run_d;
    logic          rise_q, rise_d;

    always_comb begin
        sync_d  = {sync_q[0], tach_raw};
        level_d = level_q;
        run_d   = '0;
        // run_q counts consecutive synchronized samples disagreeing with the accepted level
        if (sync_q[1] != level_q) begin
            if (int'(run_q) + 1 >= FILTER_LEN) level_d = ~level_q;
            else                               run_d   = run_q + 1'b1;
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            run_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            run_q   <= run_d;
            rise_q  <= rise_d;
        end
    end

    assign tach_rise = rise_q;

endmodule

// File: rtl/psu_tach_monitor.sv
// rtl/psu_tach_monitor.sv - windowed PSU fan tach counter with qualified under/over-speed flags
module psu_tach_monitor
    import psu_tach_monitor_pkg::*;
#(
    parameter int WINDOW_STROBES = DEF_WINDOW_STROBES,
    parameter int QUAL_WINDOWS   = DEF_QUAL_WINDOWS,
    parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
    input logic                SlowClock,
    input logic                Reset,
    psu_tach_monitor_if.slave  bus
);
    localparam int WW = (WINDOW_STROBES > 1) ? $clog2(WINDOW_STROBES) : 1;

    tach_state_t   state_q, state_d;
    logic [WW-1:0] win_q, win_d;
    logic [7:0]    pcnt_q, pcnt_d;
    logic [7:0]    count_q, count_d;
    logic          valid_q, valid_d;
    logic          low_q, low_d;
    logic          high_q, high_d;
    logic [1:0]    lqual_q, lqual_d;
    logic [1:0]    hqual_q, hqual_d;

    logic          pulse;
    logic          win_last;
    logic          win_end;
    logic [7:0]    count_final;
    tach_class_t   cls;

    tach_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk       (SlowClock),
        .rst       (Reset),
        .tach_raw  (bus.PSU1_Tach),
        .tach_rise (pulse)
    );

    assign win_last    = (int'(win_q) == WINDOW_STROBES - 1);
    assign win_end     = bus.Strobe16ms && win_last;
    assign count_final = (pulse && pcnt_q != 8'hFF) ? pcnt_q + 8'd1 : pcnt_q;
    assign cls         = classify(count_final, bus.TachLowLimit, bus.TachHighLimit);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        pcnt_d  = pcnt_q;
        count_d = count_q;
        valid_d = valid_q;
        low_d   = low_q;
        high_d  = high_q;
        lqual_d = lqual_q;
        hqual_d = hqual_q;

        if (!bus.TachEnable) begin
            state_d = ST_IDLE;
            win_d   = '0;
            pcnt_d  = '0;
            count_d = '0;
            valid_d = 1'b0;
            low_d   = 1'b0;
            high_d  = 1'b0;
            lqual_d = '0;
            hqual_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SETTLE;
                    win_d   = '0;
                    pcnt_d  = '0;
                end
                default: begin
                    pcnt_d = count_final;
                    if (bus.Strobe16ms) win_d = win_last ? '0 : win_q + 1'b1;
                    if (win_end) begin
                        // a pulse on the closing cycle also opens the next window
                        pcnt_d  = {7'd0, pulse};
                        state_d = ST_MEASURE;
                        if (state_q == ST_MEASURE) begin
                            count_d = count_final;
                            valid_d = 1'b1;
                            lqual_d = (cls == CLS_LOW)  ? qual_inc(lqual_q) : 2'd0;
                            hqual_d = (cls == CLS_HIGH) ? qual_inc(hqual_q) : 2'd0;
                            low_d   = (cls == CLS_LOW)  && (int'(qual_inc(lqual_q)) >= QUAL_WINDOWS);
                            high_d  = (cls == CLS_HIGH) && (int'(qual_inc(hqual_q)) >= QUAL_WINDOWS);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge SlowClock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            pcnt_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            low_q   <= 1'b0;
            high_q  <= 1'b0;
            lqual_q <= '0;
            hqual_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            pcnt_q  <= pcnt_d;
            count_q <= count_d;
            valid_q <= valid_d;
            low_q   <= low_d;
            high_q  <= high_d;
            lqual_q <= lqual_d;
            hqual_q <= hqual_d;
        end
    end

    assign bus.TachCount      = count_q;
    assign bus.TachValid      = valid_q;
    assign bus.PSU1_Tach_Low  = low_q;
    assign bus.PSU1_Tach_High = high_q;

endmodule

// File: tb/tb_psu_tach_monitor.sv
// tb/tb_psu_tach_monitor.sv - randomized bench for psu_tach_monitor against a behavioural model
module tb_psu_tach_monitor;
    localparam int W   = 4;
    localparam int Q   = 3;
    localparam int FL  = 3;
    localparam int SP  = 400;
    localparam int WIN = SP * W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    psu_tach_monitor_if bus();

    psu_tach_monitor #(.WINDOW_STROBES(W), .QUAL_WINDOWS(Q), .FILTER_LEN(FL)) dut (
        .SlowClock (clk),
        .Reset     (rst),
        .bus       (bus)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int tach_period = 80;
    bit tach_force = 1'b0;
    bit noise = 1'b0;
    int end_cyc = 0;
    bit end_seen = 1'b0;

    // model: filtered level follows a sliding window of synchronized samples
    bit         mr1 = 0, mr2 = 0;
    bit         sq[$];
    bit         m_lvl = 0, m_rose = 0;
    bit         m_active = 0, m_settled = 0, m_end = 0;
    int         m_strobes = 0, m_pulses = 0, m_lstreak = 0, m_hstreak = 0;
    logic [7:0] m_count = 8'd0;
    logic       m_valid = 1'b0, m_low = 1'b0, m_high = 1'b0;

    task automatic model_clear();
        mr1 = 0; mr2 = 0; sq.delete(); m_lvl = 0; m_rose = 0;
        m_active = 0; m_settled = 0; m_end = 0;
        m_strobes = 0; m_pulses = 0; m_lstreak = 0; m_hstreak = 0;
        m_count = 8'd0; m_valid = 1'b0; m_low = 1'b0; m_high = 1'b0;
    endtask

    task automatic model_edge();
        bit p, syn, diff;
        int total;
        p = m_rose;
        syn = mr2; mr2 = mr1; mr1 = bus.PSU1_Tach;
        sq.push_back(syn);
        if (sq.size() > FL) void'(sq.pop_front());
        m_rose = 0;
        if (sq.size() == FL) begin
            diff = 1;
            foreach (sq[i]) if (sq[i] == m_lvl) diff = 0;
            if (diff) begin m_lvl = !m_lvl; m_rose = m_lvl; end
        end
        m_end = 0;
        if (!bus.TachEnable) begin
            m_active = 0; m_settled = 0; m_strobes = 0; m_pulses = 0;
            m_lstreak = 0; m_hstreak = 0;
            m_count = 8'd0; m_valid = 1'b0; m_low = 1'b0; m_high = 1'b0;
        end else if (!m_active) begin
            m_active = 1; m_settled = 0; m_strobes = 0; m_pulses = 0;
        end else begin
            if (bus.Strobe16ms) m_strobes++;
            if (bus.Strobe16ms && m_strobes == W) begin
                m_end = 1;
                total = m_pulses + int'(p);
                if (m_settled) begin
                    m_count = (total > 255) ? 8'd255 : 8'(total);
                    m_valid = 1'b1;
                    if (m_count < bus.TachLowLimit) begin m_lstreak++; m_hstreak = 0; end
                    else if (m_count > bus.TachHighLimit) begin m_hstreak++; m_lstreak = 0; end
                    else begin m_lstreak = 0; m_hstreak = 0; end
                    m_low  = (m_lstreak >= Q);
                    m_high = (m_hstreak >= Q);
                end
                m_settled = 1; m_strobes = 0; m_pulses = int'(p);
            end else begin
                m_pulses += int'(p);
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) model_clear();
        else     model_edge();
    end

    initial forever begin
        @(negedge clk);
        n_cmp += 4;
        if (bus.TachCount !== m_count) begin
            n_fail++;
            if (n_fail < 40) $display("FAIL tach_count t=%0t dut=%0d model=%0d", $time, bus.TachCount, m_count);
        end
        if (bus.TachValid !== m_valid) begin
            n_fail++;
            if (n_fail < 40) $display("FAIL tach_valid t=%0t dut=%b model=%b", $time, bus.TachValid, m_valid);
        end
        if (bus.PSU1_Tach_Low !== m_low) begin
            n_fail++;
            if (n_fail < 40) $display("FAIL tach_low t=%0t dut=%b model=%b", $time, bus.PSU1_Tach_Low, m_low);
        end
        if (bus.PSU1_Tach_High !== m_high) begin
            n_fail++;
            if (n_fail < 40) $display("FAIL tach_high t=%0t dut=%b model=%b", $time, bus.PSU1_Tach_High, m_high);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        end_seen = m_end;
        if (m_end) end_cyc = cyc - 1;
        bus.Strobe16ms = (cyc % SP == SP - 1);
        if (tach_period > 0) bus.PSU1_Tach = ((cyc % tach_period) < tach_period / 2);
        else                 bus.PSU1_Tach = tach_force;
        if (noise && $urandom_range(0, 15) == 0) bus.PSU1_Tach = ~bus.PSU1_Tach;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_end(input string what);
        int k;
        k = 0;
        do begin step(); k++; end while (!end_seen && k < 3 * WIN);
        if (!end_seen) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: no window end within %0d cycles", what, 3 * WIN);
        end
    endtask

    task automatic check_all_zero(input string what);
        check({what, "_count"}, bus.TachCount, 0);
        check({what, "_valid"}, bus.TachValid, 0);
        check({what, "_low"},   bus.PSU1_Tach_Low, 0);
        check({what, "_high"},  bus.PSU1_Tach_High, 0);
    endtask

    initial begin
        int k, ts;
        bus.Strobe16ms = 0; bus.TachEnable = 0; bus.PSU1_Tach = 0;
        bus.TachLowLimit = 8'd10; bus.TachHighLimit = 8'd40;
        run(3);
        check_all_zero("reset");
        rst = 1'b0;

        // nominal speed: settle window discarded, first measurement 20
        bus.TachEnable = 1'b1;
        run($urandom_range(5, 300));
        wait_end("settle");
        check("settle_count", bus.TachCount, 0);
        check("settle_valid", bus.TachValid, 0);
        wait_end("meas1");
        check("meas1_count", bus.TachCount, 20);
        check("meas1_valid", bus.TachValid, 1);
        check("meas1_low", bus.PSU1_Tach_Low, 0);
        check("meas1_high", bus.PSU1_Tach_High, 0);

        // under-speed qualifies on the third window and clears on recovery
        tach_period = 320;
        wait_end("low_w1"); check("low_w1_flag", bus.PSU1_Tach_Low, 0);
        wait_end("low_w2"); check("low_w2_flag", bus.PSU1_Tach_Low, 0);
        wait_end("low_w3"); check("low_w3_flag", bus.PSU1_Tach_Low, 1);
        check("low_w3_count", bus.TachCount, 5);
        tach_period = 80;
        wait_end("recover");
        check("recover_low", bus.PSU1_Tach_Low, 0);
        check("recover_high", bus.PSU1_Tach_High, 0);

        // over-speed saturates the count
        tach_period = 6;
        wait_end("high_w1"); check("high_w1_flag", bus.PSU1_Tach_High, 0);
        wait_end("high_w2"); check("high_w2_flag", bus.PSU1_Tach_High, 0);
        wait_end("high_w3"); check("high_w3_flag", bus.PSU1_Tach_High, 1);
        check("high_w3_count", bus.TachCount, 255);
        check("high_w3_low", bus.PSU1_Tach_Low, 0);

        // glitches rejected; a pulse on the closing cycle counts in both windows
        tach_period = 0; tach_force = 0;
        bus.TachLowLimit = 8'd0; bus.TachHighLimit = 8'd255;
        wait_end("quiet1");
        wait_end("quiet2");
        ts = end_cyc + WIN;
        run(20);
        tach_force = 1; run(1); tach_force = 0; run(15);
        tach_force = 1; run(2); tach_force = 0; run(15);
        tach_force = 1; run(1); tach_force = 0; run(1); tach_force = 1; run(1); tach_force = 0;
        while (cyc < ts - 5) step();
        tach_force = 1; run(6); tach_force = 0;
        wait_end("glitch_win");
        check("glitch_win_count", bus.TachCount, 1);
        wait_end("next_win");
        check("next_win_count", bus.TachCount, 1);

        // disable while under-speed is flagged
        bus.TachLowLimit = 8'd10; bus.TachHighLimit = 8'd40; tach_period = 320;
        k = 0;
        while (bus.PSU1_Tach_Low !== 1'b1 && k < 6 * WIN) begin step(); k++; end
        check("pre_disable_low", bus.PSU1_Tach_Low, 1);
        run($urandom_range(100, 1000));
        bus.TachEnable = 1'b0;
        run(1);
        check_all_zero("disable");
        run(600);
        bus.TachEnable = 1'b1;
        wait_end("reen_settle");
        check("reen_settle_count", bus.TachCount, 0);
        check("reen_settle_valid", bus.TachValid, 0);
        wait_end("reen_meas");
        check("reen_meas_count", bus.TachCount, 5);
        check("reen_meas_valid", bus.TachValid, 1);

        // asynchronous reset mid-measure
        run($urandom_range(100, 800));
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        run(3);
        rst = 1'b0;
        wait_end("rst_settle");
        check("rst_settle_count", bus.TachCount, 0);
        check("rst_settle_valid", bus.TachValid, 0);
        wait_end("rst_meas");
        check("rst_meas_count", bus.TachCount, 5);
        check("rst_meas_valid", bus.TachValid, 1);

        // random soak checked by the model
        for (int it = 0; it < 6; it++) begin
            tach_period = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(6, 400));
            tach_force = 1'($urandom_range(0, 1));
            noise = 1'($urandom_range(0, 1));
            bus.TachLowLimit = 8'($urandom_range(0, 60));
            bus.TachHighLimit = 8'($urandom_range(0, 255));
            bus.TachEnable = ($urandom_range(0, 4) != 0);
            run($urandom_range(300, 1500));
        end
        noise = 0;
        run(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
